// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_ctrl
// Description : Command-driven sequencer for a 4-LED bank. A shared prescaler
//               produces a 1-cycle tick every TICK_DIV clocks; the active
//               pattern (blink-all, running light, binary count) advances once
//               every eff_period ticks. Mode/period are loaded through a
//               valid/ready command handshake.
// Ports       : Clk50M     - system clock (rising edge)
//               Rst        - synchronous active-high reset
//               cmd_valid  - command present
//               cmd_mode   - 0 OFF, 1 BLINK, 2 RUN, 3 COUNT
//               cmd_period - ticks per pattern step (0 behaves as 1)
//               cmd_ready  - controller can accept a command
//               led        - LED drive, 1 = on
//               tick       - registered 1-cycle timebase pulse
//               busy       - high while a non-OFF pattern is running
// Revision    : 1.0 - initial release
// ============================================================================
module led_seq_ctrl #(
    parameter int TICK_DIV = 25_000_000,
    parameter int CNT_W    = 25
) (
    input  logic       Clk50M,
    input  logic       Rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_mode,
    input  logic [3:0] cmd_period,
    output logic       cmd_ready,
    output logic [3:0] led,
    output logic       tick,
    output logic       busy
);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_BLINK = 2'd1;
    localparam logic [1:0] MODE_RUN   = 2'd2;
    localparam logic [1:0] MODE_COUNT = 2'd3;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] presc, presc_n;
    logic [3:0]       step, step_n;
    logic [1:0]       mode, mode_n;
    logic [3:0]       period, period_n;
    logic [3:0]       led_n;
    logic             tick_n;
    logic             ready_n;

    logic             accept;
    logic [3:0]       step_last;
    logic [3:0]       led_init;
    logic [3:0]       led_step;

    assign accept    = cmd_valid && cmd_ready;
    // eff_period - 1; a zero period behaves as a period of one
    assign step_last = (period == 4'd0) ? 4'd0 : (period - 4'd1);
    assign busy      = (state == ST_ACTIVE);

    always_comb begin
        led_init = 4'b0000;
        led_step = led;
        case (mode)
            MODE_BLINK: led_step = ~led;
            MODE_RUN: begin
                led_init = 4'b0001;
                led_step = {led[2:0], led[3]};
            end
            MODE_COUNT: led_step = led + 4'd1;
            default:    led_step = led;
        endcase
    end

    always_comb begin
        state_n  = state;
        presc_n  = presc;
        step_n   = step;
        mode_n   = mode;
        period_n = period;
        led_n    = led;
        tick_n   = 1'b0;
        ready_n  = 1'b1;

        case (state)
            ST_IDLE: begin
                presc_n = '0;
                step_n  = 4'd0;
                led_n   = 4'b0000;
                if (accept) begin
                    state_n  = ST_LOAD;
                    mode_n   = cmd_mode;
                    period_n = cmd_period;
                    ready_n  = 1'b0;
                end
            end

            ST_LOAD: begin
                presc_n = '0;
                step_n  = 4'd0;
                led_n   = led_init;
                state_n = (mode == MODE_OFF) ? ST_IDLE : ST_ACTIVE;
            end

            ST_ACTIVE: begin
                if (presc == TICK_LAST) begin
                    presc_n = '0;
                    tick_n  = 1'b1;
                    if (step == step_last) begin
                        step_n = 4'd0;
                        led_n  = led_step;
                    end else begin
                        step_n = step + 4'd1;
                    end
                end else begin
                    presc_n = presc + CNT_W'(1);
                end
                // A new command overrides a coincident step; tick still pulses
                if (accept) begin
                    state_n  = ST_LOAD;
                    mode_n   = cmd_mode;
                    period_n = cmd_period;
                    led_n    = led;
                    ready_n  = 1'b0;
                end
            end

            default: begin
                state_n = ST_IDLE;
                led_n   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge Clk50M) begin
        if (Rst) begin
            state     <= ST_IDLE;
            presc     <= '0;
            step      <= 4'd0;
            mode      <= MODE_OFF;
            period    <= 4'd0;
            led       <= 4'b0000;
            tick      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_n;
            presc     <= presc_n;
            step      <= step_n;
            mode      <= mode_n;
            period    <= period_n;
            led       <= led_n;
            tick      <= tick_n;
            cmd_ready <= ready_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_seq_ctrl
// Description : Directed self-checking bench for led_seq_ctrl with TICK_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_seq_ctrl;

    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 3;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_period;
    logic       cmd_ready;
    logic [3:0] led;
    logic       tick;
    logic       busy;

    int n_checks;
    int n_fails;

    led_seq_ctrl #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .Clk50M     (clk),
        .Rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_mode   (cmd_mode),
        .cmd_period (cmd_period),
        .cmd_ready  (cmd_ready),
        .led        (led),
        .tick       (tick),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue a command; returns one cycle after the LOAD edge (t = 0)
    task automatic send_cmd(input logic [1:0] m, input logic [3:0] p);
        cmd_valid  = 1'b1;
        cmd_mode   = m;
        cmd_period = p;
        cycle();
        cmd_valid = 1'b0;
        check_eq("ready_low_in_load", {31'd0, cmd_ready}, 32'd0);
        cycle();
        check_eq("ready_after_load", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_mode   = 2'd0;
        cmd_period = 4'd0;

        // ---------------- reset / idle
        repeat (3) cycle();
        check_eq("rst_led",   {28'd0, led}, 32'd0);
        check_eq("rst_busy",  {31'd0, busy}, 32'd0);
        check_eq("rst_tick",  {31'd0, tick}, 32'd0);
        check_eq("rst_ready", {31'd0, cmd_ready}, 32'd0);
        rst = 1'b0;
        cycle();
        check_eq("idle_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("idle_led",   {28'd0, led}, 32'd0);
        check_eq("idle_busy",  {31'd0, busy}, 32'd0);

        // ---------------- BLINK, period 2: toggle every 8 edges
        send_cmd(2'd1, 4'd2);
        check_eq("blink_init", {28'd0, led}, 32'd0);
        check_eq("blink_busy", {31'd0, busy}, 32'd1);
        for (int t = 1; t <= 24; t++) begin
            cycle();
            check_eq("blink_tick", {31'd0, tick}, ((t % 4) == 0) ? 32'd1 : 32'd0);
            check_eq("blink_led", {28'd0, led}, (((t / 8) % 2) == 1) ? 32'hF : 32'h0);
        end

        // ---------------- RUN, period 0 (as 1): step every 4 edges, wraps
        send_cmd(2'd2, 4'd0);
        check_eq("run_init", {28'd0, led}, 32'd1);
        for (int t = 1; t <= 20; t++) begin
            cycle();
            check_eq("run_led", {28'd0, led}, 32'd1 << ((t / 4) % 4));
        end

        // ---------------- COUNT, period 1: 16 steps wrap to zero
        send_cmd(2'd3, 4'd1);
        check_eq("count_init", {28'd0, led}, 32'd0);
        for (int t = 1; t <= 67; t++) begin
            cycle();
            check_eq("count_led",  {28'd0, led}, (t / 4) % 16);
            check_eq("count_busy", {31'd0, busy}, 32'd1);
        end
        check_eq("count_wrapped", {28'd0, led}, 32'd0);

        // ---------------- collision: RUN command on the step edge (t=68)
        cmd_valid  = 1'b1;
        cmd_mode   = 2'd2;
        cmd_period = 4'd1;
        cycle();
        cmd_valid = 1'b0;
        check_eq("coll_no_step", {28'd0, led}, 32'd0);
        check_eq("coll_ready",   {31'd0, cmd_ready}, 32'd0);
        cycle();
        check_eq("coll_load_led", {28'd0, led}, 32'd1);
        check_eq("coll_busy",     {31'd0, busy}, 32'd1);

        // ---------------- OFF
        send_cmd(2'd0, 4'd0);
        for (int t = 0; t < 10; t++) begin
            check_eq("off_led",  {28'd0, led}, 32'd0);
            check_eq("off_busy", {31'd0, busy}, 32'd0);
            check_eq("off_tick", {31'd0, tick}, 32'd0);
            cycle();
        end

        // ---------------- reset mid-RUN while led = 0100, on a step edge
        send_cmd(2'd2, 4'd1);
        for (int t = 1; t <= 11; t++) cycle();
        check_eq("pre_rst_led", {28'd0, led}, 32'd4);
        rst = 1'b1;
        cycle();
        check_eq("mid_rst_led",   {28'd0, led}, 32'd0);
        check_eq("mid_rst_busy",  {31'd0, busy}, 32'd0);
        check_eq("mid_rst_tick",  {31'd0, tick}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
        cycle();
        check_eq("mid_rst_tick2", {31'd0, tick}, 32'd0);
        rst = 1'b0;
        cycle();
        check_eq("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("post_rst_led",   {28'd0, led}, 32'd0);
        repeat (5) begin
            cycle();
            check_eq("post_rst_tick", {31'd0, tick}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Command-driven sequencer for the 4-LED bank on the 50 MHz board clock. It owns a shared prescaler timebase that generates a 1-cycle tick. It steps one of three LED patterns every `period` ticks: blink-all, running light, or binary count. New modes and periods arrive over a valid/ready command handshake, so upper-level logic (button decoder, UART shell) can reconfigure the LEDs without touching the timebase.

Parameters:
TICK_DIV, 25_000_000, clocks per tick (0.5 s at 50 MHz); legal range ≥2
CNT_W, 25, prescaler width; must satisfy 2^CNT_W ≥ TICK_DIV

Ports:
Clk50M  input  1  system clock, 50 MHz
Rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_mode  input  2  0 OFF, 1 BLINK, 2 RUN, 3 COUNT
cmd_period  input  4  ticks per pattern step; 0 treated as 1
cmd_ready  output  1  controller can accept a command
led  output  4  LED drive, 1 = on
tick  output  1  registered 1-cycle timebase pulse
busy  output  1  high while a non-OFF pattern is active

Behaviour:
- One clock (Clk50M). Reset is synchronous and active-high (Rst); all state is sampled only on the rising edge.
- While Rst=1 at an edge, the following take these values:
  - state=IDLE
  - led=4'b0000
  - tick=0, busy=0, cmd_ready=0
  - prescaler=0, step counter=0
  - mode and period registers cleared to 0
  - cmd_ready goes to 1 on the first edge after Rst deasserts.
- A reset mid-pattern aborts immediately; no partial step completes.
- Handshake:
  - A command is accepted on an edge where cmd_valid=1 and cmd_ready=1.
  - cmd_mode and cmd_period are captured on that edge.
  - cmd_ready=1 in IDLE and ACTIVE, and 0 in LOAD.
  - cmd_valid may be held high; exactly one acceptance occurs per ready cycle.
- FSM states:
  - IDLE: led=0, busy=0, prescaler halted at 0. An accepted command goes to LOAD.
  - LOAD (exactly 1 cycle):
    - Clear prescaler and step counter.
    - Set led to the initial pattern: BLINK 0000, RUN 0001, COUNT 0000, OFF 0000.
    - Next state is IDLE if mode=OFF, otherwise ACTIVE.
  - ACTIVE:
    - busy=1.
    - Prescaler increments each cycle. On an edge where prescaler==TICK_DIV-1: prescaler←0, tick←1. Otherwise tick←0.
    - On each tick edge: if step==eff_period-1, then step←0 and led steps; otherwise step←step+1.
    - eff_period = (period==0) ? 1 : period.
    - An accepted command goes to LOAD.
- Pattern steps:
  - BLINK: led←~led.
  - RUN: rotate left; 1000 wraps to 0001.
  - COUNT: led←led+1 modulo 16; 1111 wraps to 0000.
- Timing: the first tick occurs TICK_DIV edges after the LOAD edge. The first led step occurs eff_period·TICK_DIV edges after the LOAD edge, then every eff_period·TICK_DIV edges after that.
- Simultaneous command acceptance and step/tick edge: the command wins. The led step is discarded, tick still pulses that cycle, and LOAD reinitialises everything.
- Command re-issuing the current mode: full restart via LOAD (pattern and phase reset).
- tick is 0 in IDLE and LOAD.

Test Plan:
- Reset / idle (TICK_DIV=4 in all tests): hold Rst for 3 cycles, then release. Required: led=0000, busy=0, tick=0; cmd_ready=1 one cycle after release.
- BLINK: send mode=1, period=2. Required:
  - cmd_ready=0 for 1 cycle; led=0000 after LOAD.
  - tick every 4 cycles.
  - led=1111 at 8 cycles after LOAD, 0000 at 16, 1111 at 24.
- RUN with wrap: send mode=2, period=0 (treated as 1). Required: led sequence 0001→0010→0100→1000→0001, one step per 4 cycles after LOAD.
- COUNT with wrap: send mode=3, period=1 and run 16 steps. Required: led counts 0000..1111, then 0000 on the 16th step; busy=1 throughout.
- Collision and OFF:
  - Mid-COUNT, assert mode=2 on exactly a step edge. Required: led does not increment; after LOAD, led=0001.
  - Then send mode=0. Required: led=0000, busy=0, tick stays 0.
- Reset mid-operation: assert Rst during RUN with led=0100. Required: next edge led=0000, state IDLE; no tick pulse during reset.
